// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage and register file.
package wb_pkg;

  typedef enum logic [2:0] {
    WB_ALU   = 3'd0,
    WB_MEM   = 3'd1,
    WB_PC4   = 3'd2,
    WB_IMM   = 3'd3,
    WB_PCIMM = 3'd4
  } wb_src_e;

  typedef logic [4:0] reg_idx_t;

  localparam int unsigned PC_INC   = 4;
  localparam int unsigned SB_CNT_W = 2;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-write counters, hazard busy flags and sticky overflow flag.
module wb_scoreboard
  import wb_pkg::*;
#(
  parameter int unsigned NREG = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     iss_en_i,
  input  reg_idx_t iss_rd_i,
  input  logic     wb_en_i,
  input  reg_idx_t wb_rd_i,
  input  reg_idx_t rs1_idx_i,
  input  reg_idx_t rs2_idx_i,
  output logic     rs1_busy_c,
  output logic     rs2_busy_c,
  output logic     overflow_o
);

  localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [SB_CNT_W-1:0] CNT_ONE = SB_CNT_W'(1);

  logic [SB_CNT_W-1:0] cnt_q [NREG];
  logic [SB_CNT_W-1:0] cnt_d [NREG];
  logic                ovf_q, ovf_d;
  logic                inc, dec;

  assign inc = iss_en_i && (iss_rd_i != '0);
  // A retiring slot decrements even if its source code suppressed the write.
  assign dec = wb_en_i && (wb_rd_i != '0);

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (!(inc && dec && (iss_rd_i == wb_rd_i))) begin
      if (inc) begin
        if (cnt_q[iss_rd_i] == CNT_MAX) ovf_d = 1'b1;
        else cnt_d[iss_rd_i] = cnt_q[iss_rd_i] + CNT_ONE;
      end
      if (dec && (cnt_q[wb_rd_i] != '0)) cnt_d[wb_rd_i] = cnt_q[wb_rd_i] - CNT_ONE;
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Last outstanding write retiring this cycle is covered by the bypass.
  assign rs1_busy_c = (rs1_idx_i != '0) && (cnt_q[rs1_idx_i] != '0) &&
                      !((cnt_q[rs1_idx_i] == CNT_ONE) && dec && (wb_rd_i == rs1_idx_i));
  assign rs2_busy_c = (rs2_idx_i != '0) && (cnt_q[rs2_idx_i] != '0) &&
                      !((cnt_q[rs2_idx_i] == CNT_ONE) && dec && (wb_rd_i == rs2_idx_i));

  assign overflow_o = ovf_q;

endmodule

// File: rtl/wb_writeback_regfile.sv
// Writeback stage: source mux, 32x32 register file with write-first bypass,
// and pending-write scoreboard for decode hazard detection.
module wb_writeback_regfile
  import wb_pkg::*;
#(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NREG       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     MemRdDataIn,
  input  logic [DATA_W-1:0]     MemALUresultIn,
  input  logic [DM_ADDRESS-1:0] PCin,
  input  logic [DATA_W-1:0]     immIn,
  input  logic                  RegWrtEnIn,
  input  logic [2:0]            RegWrtSrcIn,
  input  logic [4:0]            RegDstIn,
  input  logic [4:0]            rs1_addr,
  input  logic [4:0]            rs2_addr,
  input  logic                  iss_en,
  input  logic [4:0]            iss_rd,
  output logic [DATA_W-1:0]     rs1_data,
  output logic [DATA_W-1:0]     rs2_data,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  wb_we,
  output logic                  sb_overflow
);

  logic [DATA_W-1:0] regs_q [NREG];

  // Write-back value select; unused codes yield zero.
  always_comb begin
    wb_data = '0;
    case (RegWrtSrcIn)
      WB_ALU:   wb_data = MemALUresultIn;
      WB_MEM:   wb_data = MemRdDataIn;
      WB_PC4:   wb_data = DATA_W'(PCin) + DATA_W'(PC_INC);
      WB_IMM:   wb_data = immIn;
      WB_PCIMM: wb_data = DATA_W'(PCin) + immIn;
      default:  wb_data = '0;
    endcase
  end

  assign wb_we = RegWrtEnIn && (RegDstIn != 5'd0) && (RegWrtSrcIn <= 3'(WB_PCIMM));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wb_we) begin
      regs_q[RegDstIn] <= wb_data;
    end
  end

  assign rs1_data = (rs1_addr == 5'd0)                ? '0      :
                    (wb_we && (RegDstIn == rs1_addr)) ? wb_data : regs_q[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0)                ? '0      :
                    (wb_we && (RegDstIn == rs2_addr)) ? wb_data : regs_q[rs2_addr];

  wb_scoreboard #(.NREG(NREG)) u_sb (
    .clk        (clk),
    .rst_n      (rst),
    .iss_en_i   (iss_en),
    .iss_rd_i   (reg_idx_t'(iss_rd)),
    .wb_en_i    (RegWrtEnIn),
    .wb_rd_i    (reg_idx_t'(RegDstIn)),
    .rs1_idx_i  (reg_idx_t'(rs1_addr)),
    .rs2_idx_i  (reg_idx_t'(rs2_addr)),
    .rs1_busy_c (rs1_busy),
    .rs2_busy_c (rs2_busy),
    .overflow_o (sb_overflow)
  );

endmodule

// File: tb/tb_wb_writeback_regfile.sv
// Scoreboard bench for wb_writeback_regfile: expectations are queued as stimulus is driven.
module tb_wb_writeback_regfile;

  logic        clk;
  logic        rst;
  logic [31:0] MemRdDataIn, MemALUresultIn, immIn;
  logic [8:0]  PCin;
  logic        RegWrtEnIn;
  logic [2:0]  RegWrtSrcIn;
  logic [4:0]  RegDstIn, rs1_addr, rs2_addr, iss_rd;
  logic        iss_en;
  logic [31:0] rs1_data, rs2_data, wb_data;
  logic        rs1_busy, rs2_busy, wb_we, sb_overflow;

  wb_writeback_regfile dut (
    .clk(clk), .rst(rst),
    .MemRdDataIn(MemRdDataIn), .MemALUresultIn(MemALUresultIn), .PCin(PCin), .immIn(immIn),
    .RegWrtEnIn(RegWrtEnIn), .RegWrtSrcIn(RegWrtSrcIn), .RegDstIn(RegDstIn),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .iss_en(iss_en), .iss_rd(iss_rd),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wb_data(wb_data), .wb_we(wb_we), .sb_overflow(sb_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int O_RS1D = 0, O_RS2D = 1, O_RS1B = 2, O_RS2B = 3, O_WBD = 4, O_WBWE = 5, O_OVF = 6;

  typedef struct {
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic string tag_of(input int sel);
    case (sel)
      O_RS1D:  return "rs1_data";
      O_RS2D:  return "rs2_data";
      O_RS1B:  return "rs1_busy";
      O_RS2B:  return "rs2_busy";
      O_WBD:   return "wb_data";
      O_WBWE:  return "wb_we";
      default: return "sb_overflow";
    endcase
  endfunction

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      O_RS1D:  return rs1_data;
      O_RS2D:  return rs2_data;
      O_RS1B:  return 32'(rs1_busy);
      O_RS2B:  return 32'(rs2_busy);
      O_WBD:   return wb_data;
      O_WBWE:  return 32'(wb_we);
      default: return 32'(sb_overflow);
    endcase
  endfunction

  function automatic void expect_v(input int sel, input logic [31:0] v);
    exp_t e;
    e.sel = sel;
    e.exp = v;
    sb_q.push_back(e);
  endfunction

  // Compare every queued expectation against the settled combinational outputs.
  task automatic drain();
    exp_t e;
    #2;
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_eq(tag_of(e.sel), observe(e.sel), e.exp);
    end
  endtask

  task automatic idle_inputs();
    RegWrtEnIn  = 1'b0;
    RegWrtSrcIn = 3'd0;
    RegDstIn    = 5'd0;
    iss_en      = 1'b0;
    iss_rd      = 5'd0;
    rs1_addr    = 5'd0;
    rs2_addr    = 5'd0;
  endtask

  task automatic tick();
    drain();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic wb(input logic [4:0] rd, input logic [2:0] src, input logic [31:0] alu);
    RegWrtEnIn     = 1'b1;
    RegDstIn       = rd;
    RegWrtSrcIn    = src;
    MemALUresultIn = alu;
  endtask

  task automatic issue(input logic [4:0] rd);
    iss_en = 1'b1;
    iss_rd = rd;
  endtask

  initial begin
    rst = 1'b0;
    MemRdDataIn = '0; MemALUresultIn = '0; immIn = '0; PCin = '0;
    idle_inputs();
    #12 rst = 1'b1;
    @(posedge clk); #1;

    // Build some state, then reset mid-cycle and confirm it is discarded.
    wb(5, 3'd0, 32'h55); tick();
    issue(5); tick();
    rs1_addr = 5; expect_v(O_RS1D, 32'h55); expect_v(O_RS1B, 1); tick();
    rs1_addr = 5; rs2_addr = 31;
    #2 rst = 1'b0;
    expect_v(O_RS1D, 0); expect_v(O_RS2D, 0); expect_v(O_RS1B, 0);
    expect_v(O_RS2B, 0); expect_v(O_OVF, 0);
    drain();
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1; idle_inputs();

    // Source mux, one code per cycle, result read back the following cycle.
    wb(3, 3'd0, 32'hDEADBEEF); expect_v(O_WBD, 32'hDEADBEEF); expect_v(O_WBWE, 1); tick();
    rs1_addr = 3; expect_v(O_RS1D, 32'hDEADBEEF);
    wb(10, 3'd2, 32'h0); PCin = 9'h1FC; expect_v(O_WBD, 32'h200); tick();
    rs1_addr = 10; expect_v(O_RS1D, 32'h200);
    wb(8, 3'd1, 32'h0); MemRdDataIn = 32'hCAFE0001; expect_v(O_WBD, 32'hCAFE0001); tick();
    rs2_addr = 8; expect_v(O_RS2D, 32'hCAFE0001);
    wb(11, 3'd3, 32'h0); immIn = 32'h77; expect_v(O_WBD, 32'h77); tick();
    rs1_addr = 11; expect_v(O_RS1D, 32'h77); tick();
    wb(11, 3'd4, 32'h0); PCin = 9'h010; immIn = 32'hFFFFFFF0;
    expect_v(O_WBD, 32'h0); expect_v(O_WBWE, 1); tick();
    rs1_addr = 11; expect_v(O_RS1D, 32'h0); tick();
    wb(12, 3'd6, 32'h12345678); expect_v(O_WBD, 32'h0); expect_v(O_WBWE, 0); tick();
    rs1_addr = 12; expect_v(O_RS1D, 32'h0); tick();

    // x0 protection with and without the bypass path active.
    wb(0, 3'd0, 32'h1234); rs1_addr = 0;
    expect_v(O_WBWE, 0); expect_v(O_WBD, 32'h1234); expect_v(O_RS1D, 0); tick();
    rs1_addr = 0; expect_v(O_RS1D, 0); tick();

    // Write-first bypass hides the old value on both ports.
    wb(7, 3'd0, 32'h11111111); tick();
    wb(7, 3'd0, 32'hA5A5A5A5); rs1_addr = 7; rs2_addr = 7;
    expect_v(O_RS1D, 32'hA5A5A5A5); expect_v(O_RS2D, 32'hA5A5A5A5); tick();
    rs1_addr = 7; expect_v(O_RS1D, 32'hA5A5A5A5); tick();

    // Scoreboard: two in flight on x9, retire one at a time.
    issue(9); tick();
    issue(9); tick();
    rs1_addr = 9; expect_v(O_RS1B, 1); tick();
    wb(9, 3'd0, 32'h9); rs1_addr = 9; expect_v(O_RS1B, 1); tick();
    wb(9, 3'd0, 32'h9); rs1_addr = 9; expect_v(O_RS1B, 0); tick();
    rs1_addr = 9; expect_v(O_RS1B, 0); tick();
    issue(9); tick();
    issue(9); wb(9, 3'd0, 32'h9); rs2_addr = 9; expect_v(O_RS2B, 0); tick();
    rs2_addr = 9; expect_v(O_RS2B, 1); tick();
    wb(9, 3'd0, 32'h9); tick();
    rs2_addr = 9; expect_v(O_RS2B, 0); tick();

    // An invalid source still retires its slot.
    issue(13); tick();
    wb(13, 3'd7, 32'h0); rs1_addr = 13; expect_v(O_WBWE, 0); expect_v(O_RS1B, 0); tick();
    rs1_addr = 13; expect_v(O_RS1B, 0); tick();

    // Overflow: fourth issue saturates at 3 and sets the sticky flag.
    issue(4); tick();
    issue(4); tick();
    issue(4); tick();
    rs1_addr = 4; expect_v(O_OVF, 0); expect_v(O_RS1B, 1); tick();
    issue(4); tick();
    rs1_addr = 4; expect_v(O_OVF, 1); expect_v(O_RS1B, 1); tick();
    wb(4, 3'd0, 32'h4); tick();
    wb(4, 3'd0, 32'h4); tick();
    rs1_addr = 4; expect_v(O_RS1B, 1); tick();
    wb(4, 3'd0, 32'h4); tick();
    rs1_addr = 4; expect_v(O_RS1B, 0); expect_v(O_OVF, 1); tick();
    rst = 1'b0;
    expect_v(O_OVF, 0);
    drain();
    rst = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_writeback_regfile.md
Name: wb_writeback_regfile

Overview:
- Consumer end of the MEM/WB pipeline register, i.e. the writeback stage plus the architectural register file.
- Takes the registered WB bundle, selects the write-back value by source code, and writes the 32x32 register file.
- Serves two decode read ports with same-cycle write-through bypass.
- Keeps a per-register pending-write scoreboard so decode can detect RAW hazards on in-flight destinations.

Parameters:
- DM_ADDRESS, 9, PC width in bits.
- DATA_W, 32, datapath width.
- NREG, 32, number of architectural registers (index width 5).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- MemRdDataIn  in  DATA_W  load data from MEM/WB register
- MemALUresultIn  in  DATA_W  ALU result from MEM/WB register
- PCin  in  DM_ADDRESS  instruction PC from MEM/WB register
- immIn  in  DATA_W  immediate from MEM/WB register
- RegWrtEnIn  in  1  write enable from MEM/WB register
- RegWrtSrcIn  in  3  write-source select
- RegDstIn  in  5  destination index
- rs1_addr, rs2_addr  in  5 each  decode read indices
- iss_en  in  1  decode issues an instruction that writes a register
- iss_rd  in  5  destination of the issued instruction
- rs1_data, rs2_data  out  DATA_W each  read data, bypassed
- rs1_busy, rs2_busy  out  1 each  source has an outstanding write not yet visible
- wb_data  out  DATA_W  selected write-back value, for forwarding
- wb_we  out  1  effective write strobe
- sb_overflow  out  1  sticky: issue attempted on a register already at max pending

Behaviour:
- Reset (rst=0, asynchronous):
  - All registers and pending counters clear to 0; sb_overflow=0.
  - Combinational outputs follow from the cleared state: rs*_data=0, rs*_busy=0.
  - Reset mid-operation discards all in-flight state immediately.
- Source select, combinational (RegWrtSrcIn):
  - 0 → MemALUresultIn
  - 1 → MemRdDataIn
  - 2 → zero-extended PCin+4, with the add done at DATA_W
  - 3 → immIn
  - 4 → zero-extended PCin + immIn, modulo 2^DATA_W
  - 5-7 → 0, and wb_we forced to 0
- wb_we = RegWrtEnIn & (RegDstIn!=0) & (RegWrtSrcIn<=4).
- Register write: on posedge clk when wb_we, regs[RegDstIn] <= wb_data. Register 0 always reads 0 and is never written.
- Reads are combinational. If wb_we and RegDstIn==rsN_addr (nonzero), rsN_data = wb_data (write-first bypass); otherwise the stored value. Zero-latency visibility.
- Scoreboard: 2-bit pending count per register; entry 0 is always 0.
  - Each cycle: inc = iss_en & iss_rd!=0; dec = RegWrtEnIn & RegDstIn!=0.
  - A dec counts even when wb_we is 0 because of an invalid source code, so the slot retires.
  - If inc and dec target the same register, the count is unchanged.
  - Otherwise inc adds 1 to iss_rd and dec subtracts 1 from RegDstIn, both in the same cycle.
  - Underflow (dec at count 0): count holds at 0, no flag.
  - Overflow (inc at count 3): count holds at 3 and sb_overflow sets; it clears only on reset.
- rsN_busy = count[rsN_addr]!=0, except 0 when count==1 and dec targets that register this cycle, because the bypass covers it. Always 0 for index 0.
- rsN_busy does not include a same-cycle iss_en; decode owns that check.

Decomposition:
- Package wb_pkg:
  - typedef wb_src_e, 3-bit enum: WB_ALU=0, WB_MEM=1, WB_PC4=2, WB_IMM=3, WB_PCIMM=4.
  - typedef reg_idx_t, 5-bit.
  - constant PC_INC=4.
- One sub-module, wb_scoreboard: the counters, busy logic and overflow flag.
- Source mux, storage and bypass stay in the top.

Test Plan:
- Reset then read: assert rst=0 mid-run, release; rs1_addr=5, rs2_addr=31 → rs1_data=0, rs2_data=0, busy=0, sb_overflow=0.
- Source mux, each code:
  - RegWrtEnIn=1, RegDstIn=3, src=0, ALU=0xDEADBEEF → next cycle regs[3]=0xDEADBEEF.
  - src=2, PCin=0x1FC → 0x00000200.
  - src=4, PCin=0x010, imm=0xFFFFFFF0 → 0x00000000.
  - src=6 → no write, wb_we=0.
- x0 protection: write 0x1234 to rd=0 → wb_we=0; rs1_addr=0 reads 0 with and without bypass.
- Bypass: same cycle write rd=7 with 0xA5A5A5A5 and rs1_addr=rs2_addr=7 → both outputs 0xA5A5A5A5 combinationally, old value not visible.
- Scoreboard: issue rd=9 twice → count 2, rs1_busy=1; first WB to 9 → still busy; second WB → busy=0 during the WB cycle. Simultaneous iss_rd=9 and WB rd=9 at count 1 → count stays 1.
- Overflow: issue rd=4 four times with no WB → count 3, sb_overflow=1 after the fourth; three WBs → count 0; flag stays 1 until rst=0.
